jtopl_opmix: RTL and testbench

//  Consumer of the serial operator output stream. Takes one signed 14-bit

---
 rtl/jtopl_opmix.sv | 90 +++++++++
 tb/tb_jtopl_opmix.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/jtopl_opmix.sv
// Operator output mixer: accumulates audible operator slots into one saturated sample per frame.
// Optional JTOPL_OPMIX_MUTE_EN adds a ch_mute[8:0] input that silences whole channels.
module jtopl_opmix #(
  parameter int SLOTS = 18,
  parameter int ACCW  = 18,
  parameter int OUTW  = 16
) (
  input  logic                   rst,
  input  logic                   clk,
  input  logic                   cenop,
  input  logic                   zero,
  input  logic signed [13:0]     op_result,
  input  logic        [8:0]      con,
`ifdef JTOPL_OPMIX_MUTE_EN
  input  logic        [8:0]      ch_mute,
`endif
  output logic signed [OUTW-1:0] snd,
  output logic                   snd_sample,
  output logic                   snd_sat
);

  localparam int CW = $clog2(SLOTS);
  // One guard bit over ACCW: a full frame of -8192 reaches -147456, beyond 18 signed bits.
  localparam int SUMW = ACCW + 1;
  localparam logic signed [SUMW-1:0] MAXV = SUMW'((1 <<< (OUTW-1)) - 1);
  localparam logic signed [SUMW-1:0] MINV = SUMW'(-(1 <<< (OUTW-1)));

  logic        [CW-1:0]   cnt;
  logic        [CW-1:0]   cur;
  logic        [CW-1:0]   grp;
  logic        [CW-1:0]   rem;
  logic        [3:0]      ch;
  logic                   op;
  logic                   audible;
  logic                   last;
  logic signed [SUMW-1:0] acc;
  logic signed [SUMW-1:0] contrib;
  logic signed [SUMW-1:0] total;
  logic signed [OUTW-1:0] clamp_val;
  logic                   clip;

  // Slot decode: zero overrides the free-running count so a resync discards the partial frame.
  always_comb begin
    cur     = zero ? '0 : cnt;
    grp     = cur / CW'(6);
    rem     = cur % CW'(6);
    op      = rem >= CW'(3);
    ch      = 4'(grp * CW'(3) + (op ? rem - CW'(3) : rem));
    audible = op | con[ch];
`ifdef JTOPL_OPMIX_MUTE_EN
    if (ch_mute[ch]) audible = 1'b0;
`endif
    contrib = audible ? SUMW'(op_result) : '0;
    total   = ((cur == '0) ? '0 : acc) + contrib;
    last    = cur == CW'(SLOTS-1);
  end

  always_comb begin
    clamp_val = total[OUTW-1:0];
    clip      = 1'b0;
    if (total > MAXV) begin
      clamp_val = MAXV[OUTW-1:0];
      clip      = 1'b1;
    end else if (total < MINV) begin
      clamp_val = MINV[OUTW-1:0];
      clip      = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      acc        <= '0;
      snd        <= '0;
      snd_sample <= 1'b0;
      snd_sat    <= 1'b0;
    end else if (cenop) begin
      cnt <= last ? '0 : cur + CW'(1);
      acc <= total;
      if (last) begin
        snd        <= clamp_val;
        snd_sat    <= clip;
        snd_sample <= 1'b1;
      end else begin
        snd_sample <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jtopl_opmix.sv
// Self-checking bench for jtopl_opmix against a frame-level reference model.
// Define JTOPL_OPMIX_MUTE_EN to also exercise the ch_mute input.
module tb_jtopl_opmix;

  logic               rst;
  logic               clk;
  logic               cenop;
  logic               zero;
  logic signed [13:0] op_result;
  logic [8:0]         con;
`ifdef JTOPL_OPMIX_MUTE_EN
  logic [8:0]         ch_mute;
`endif
  logic signed [15:0] snd;
  logic               snd_sample;
  logic               snd_sat;

  int tests;
  int fails;

  // Reference model state
  int m_pos;
  int m_sum;
  int exp_snd;
  bit exp_sat;
  bit exp_sample;

  jtopl_opmix dut (
    .rst(rst),
    .clk(clk),
    .cenop(cenop),
    .zero(zero),
    .op_result(op_result),
    .con(con),
`ifdef JTOPL_OPMIX_MUTE_EN
    .ch_mute(ch_mute),
`endif
    .snd(snd),
    .snd_sample(snd_sample),
    .snd_sat(snd_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_pos = 0; m_sum = 0; exp_snd = 0; exp_sat = 0; exp_sample = 0;
  endtask

  // One operator slot: a single cenop edge followed by an idle clock with cenop low.
  task automatic cen_cycle(input bit z, input int v);
    int slot, ch;
    bit carrier, aud;
    @(negedge clk);
    zero = z; op_result = 14'(v); cenop = 1'b1;
    slot    = z ? 0 : m_pos;
    ch      = (slot / 6) * 3 + slot % 3;
    carrier = (slot % 6) >= 3;
    aud     = carrier || con[ch];
`ifdef JTOPL_OPMIX_MUTE_EN
    if (ch_mute[ch]) aud = 0;
`endif
    if (slot == 0) m_sum = 0;
    if (aud) m_sum += v;
    if (slot == 17) begin
      exp_sample = 1;
      exp_sat    = (m_sum > 32767) || (m_sum < -32768);
      exp_snd    = (m_sum > 32767) ? 32767 : (m_sum < -32768) ? -32768 : m_sum;
    end else begin
      exp_sample = 0;
    end
    m_pos = (slot == 17) ? 0 : slot + 1;
    @(posedge clk); #1;
    cenop = 1'b0; zero = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cenop = 0; zero = 0; op_result = '0; con = '0;
`ifdef JTOPL_OPMIX_MUTE_EN
    ch_mute = '0;
`endif
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    tests++; if (snd !== 16'sd0) begin fails++; $display("[TB] FAIL reset_snd got %0d want 0", snd); end
    tests++; if (snd_sample !== 1'b0) begin fails++; $display("[TB] FAIL reset_sample got %b want 0", snd_sample); end
    tests++; if (snd_sat !== 1'b0) begin fails++; $display("[TB] FAIL reset_sat got %b want 0", snd_sat); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_carriers();
    int pulses;
    con = 9'h000;
    for (int s = 0; s < 18; s++) cen_cycle(s == 0, ((s % 6) >= 3) ? 100 : 4000);
    tests++; if (snd !== 16'sd900) begin fails++; $display("[TB] FAIL carriers_snd got %0d want 900", snd); end
    tests++; if (snd_sat !== 1'b0) begin fails++; $display("[TB] FAIL carriers_sat got %b want 0", snd_sat); end
    tests++; if (snd_sample !== 1'b1) begin fails++; $display("[TB] FAIL carriers_pulse got %b want 1", snd_sample); end
    pulses = 0;
    for (int s = 0; s < 18; s++) begin
      cen_cycle(1'b0, ((s % 6) >= 3) ? 100 : 4000);
      if (snd_sample === 1'b1) pulses++;
    end
    tests++; if (pulses !== 1) begin fails++; $display("[TB] FAIL carriers_pulse_count got %0d want 1", pulses); end
    tests++; if (snd !== 16'(exp_snd)) begin fails++; $display("[TB] FAIL carriers_model got %0d want %0d", snd, exp_snd); end
  endtask

  task automatic test_saturation();
    con = 9'h1FF;
    for (int s = 0; s < 18; s++) cen_cycle(s == 0, 4000);
    tests++; if (snd !== 16'sd32767) begin fails++; $display("[TB] FAIL sat_pos_snd got %0d want 32767", snd); end
    tests++; if (snd_sat !== 1'b1) begin fails++; $display("[TB] FAIL sat_pos_flag got %b want 1", snd_sat); end
    for (int s = 0; s < 18; s++) cen_cycle(s == 0, -8192);
    tests++; if (snd !== -16'sd32768) begin fails++; $display("[TB] FAIL sat_neg_snd got %0d want -32768", snd); end
    tests++; if (snd_sat !== 1'b1) begin fails++; $display("[TB] FAIL sat_neg_flag got %b want 1", snd_sat); end
  endtask

  task automatic test_con_select();
    con = 9'h001;
    for (int s = 0; s < 18; s++) cen_cycle(s == 0, (s == 0) ? 10 : (s == 3) ? 20 : 0);
    tests++; if (snd !== 16'sd30) begin fails++; $display("[TB] FAIL con_add_snd got %0d want 30", snd); end
    tests++; if (snd_sat !== 1'b0) begin fails++; $display("[TB] FAIL con_add_sat got %b want 0", snd_sat); end
    con = 9'h000;
    for (int s = 0; s < 18; s++) cen_cycle(s == 0, (s == 0) ? 10 : (s == 3) ? 20 : 0);
    tests++; if (snd !== 16'sd20) begin fails++; $display("[TB] FAIL con_fm_snd got %0d want 20", snd); end
  endtask

  task automatic test_resync();
    int pulse_at;
    con = 9'h000;
    for (int s = 0; s < 18; s++) cen_cycle(s == 0, 100);
    for (int s = 0; s < 7; s++) cen_cycle(s == 0, 50);
    pulse_at = -1;
    for (int k = 0; k < 18; k++) begin
      cen_cycle(k == 0, 200);
      if (snd_sample === 1'b1 && pulse_at < 0) pulse_at = k;
      if (k < 17) begin
        tests++; if (snd !== 16'sd900) begin fails++; $display("[TB] FAIL resync_hold k=%0d got %0d want 900", k, snd); end
      end
    end
    tests++; if (pulse_at !== 17) begin fails++; $display("[TB] FAIL resync_pulse_pos got %0d want 17", pulse_at); end
    tests++; if (snd !== 16'sd1800) begin fails++; $display("[TB] FAIL resync_snd got %0d want 1800", snd); end
  endtask

  task automatic test_reset_mid();
    int pulse_at;
    con = 9'h1FF;
    for (int s = 0; s < 10; s++) cen_cycle(s == 0, 1000);
    @(negedge clk); rst = 1'b1; #1;
    tests++; if (snd !== 16'sd0) begin fails++; $display("[TB] FAIL rst_mid_snd got %0d want 0", snd); end
    tests++; if (snd_sample !== 1'b0) begin fails++; $display("[TB] FAIL rst_mid_sample got %b want 0", snd_sample); end
    tests++; if (snd_sat !== 1'b0) begin fails++; $display("[TB] FAIL rst_mid_sat got %b want 0", snd_sat); end
    @(negedge clk); rst = 1'b0;
    model_reset();
    con = 9'h000;
    pulse_at = -1;
    for (int k = 0; k < 18; k++) begin
      cen_cycle(1'b0, ((k % 6) >= 3) ? 100 : 4000);
      if (snd_sample === 1'b1 && pulse_at < 0) pulse_at = k;
    end
    tests++; if (pulse_at !== 17) begin fails++; $display("[TB] FAIL rst_first_pulse got %0d want 17", pulse_at); end
    tests++; if (snd !== 16'sd900) begin fails++; $display("[TB] FAIL rst_first_snd got %0d want 900", snd); end
  endtask

`ifdef JTOPL_OPMIX_MUTE_EN
  task automatic test_mute();
    con = 9'h000; ch_mute = 9'h002;
    for (int s = 0; s < 18; s++) cen_cycle(s == 0, ((s % 6) >= 3) ? 100 : 4000);
    tests++; if (snd !== 16'sd800) begin fails++; $display("[TB] FAIL mute_one_snd got %0d want 800", snd); end
    ch_mute = 9'h1FF;
    for (int s = 0; s < 18; s++) cen_cycle(s == 0, ((s % 6) >= 3) ? 100 : 4000);
    tests++; if (snd !== 16'sd0) begin fails++; $display("[TB] FAIL mute_all_snd got %0d want 0", snd); end
    ch_mute = 9'h000;
  endtask
`endif

  task automatic test_random();
    int v;
    bit z;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) con = 9'($urandom);
      z = ($urandom_range(0, 40) == 0);
      case ($urandom_range(0, 5))
        0:       v = 8191;
        1:       v = -8192;
        default: v = int'($urandom_range(0, 16383)) - 8192;
      endcase
      cen_cycle(z, v);
      tests++;
      if (snd_sample !== exp_sample || snd !== 16'(exp_snd) || snd_sat !== exp_sat) begin
        fails++;
        $display("[TB] FAIL random i=%0d got snd=%0d sat=%b smp=%b want snd=%0d sat=%b smp=%b",
                 i, snd, snd_sat, snd_sample, exp_snd, exp_sat, exp_sample);
      end
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    test_reset();
    test_carriers();
    test_saturation();
    test_con_select();
    test_resync();
    test_reset_mid();
`ifdef JTOPL_OPMIX_MUTE_EN
    test_mute();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout got running want finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
